// File: rtl/multi_dataflow_job_fsm.sv
// Job sequencer for multi_dataflow HWPEs: runs nb+1 iterations of
// request / compute / beat-count / completion-wait per started job.
module multi_dataflow_job_fsm #(
  parameter int N_IN   = 2,
  parameter int N_OUT  = 1,
  parameter int CNT_W  = 32,
  parameter int ITER_W = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   start_i,
  input  logic [ITER_W-1:0]      cfg_nb_iter_i,
  input  logic [CNT_W-1:0]       cfg_cnt_limit_i,
  output logic [N_IN+N_OUT-1:0]  stream_req_o,
  input  logic [N_IN+N_OUT-1:0]  stream_ready_i,
  input  logic [N_IN+N_OUT-1:0]  stream_done_i,
  input  logic [N_OUT-1:0]       out_beat_i,
  output logic                   engine_start_o,
  input  logic                   engine_done_i,
  output logic                   busy_o,
  output logic [ITER_W-1:0]      iter_o,
  output logic                   done_o
);

  localparam int N_S = N_IN + N_OUT;

  typedef enum logic [2:0] {
    IDLE, REQ, COMPUTE, UPDATE, TERMINATE
  } state_e;

  state_e             state_q, state_d;
  logic               busy_q;
  logic [ITER_W-1:0]  nb_q, iter_q;
  logic [CNT_W-1:0]   lim_q;
  logic [CNT_W-1:0]   cnt_q [N_OUT];
  logic [N_S-1:0]     sdone_q;
  logic               edone_q;
  logic [N_OUT-1:0]   ch_done;
  logic               all_ready;
  logic               all_done;
  logic               accept;
  logic               last_iter;

  assign all_ready = &stream_ready_i;
  assign accept    = (state_q == REQ) && all_ready;
  assign last_iter = (iter_q == nb_q);

  always_comb begin
    ch_done = '0;
    for (int j = 0; j < N_OUT; j++)
      ch_done[j] = (cnt_q[j] == lim_q);
  end

  // registered flags only: a pulse in cycle t permits exit in t+1
  assign all_done = (&sdone_q) && edone_q && (&ch_done);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
    end else if (clear_i) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (start_i) state_d = REQ;
      REQ:       if (all_ready) state_d = COMPUTE;
      COMPUTE:   if (all_done) state_d = UPDATE;
      UPDATE:    state_d = last_iter ? TERMINATE : REQ;
      TERMINATE: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    stream_req_o   = '0;
    engine_start_o = 1'b0;
    done_o         = 1'b0;
    unique case (state_q)
      REQ: begin
        stream_req_o   = '1;
        engine_start_o = all_ready;
      end
      TERMINATE: done_o = 1'b1;
      default: ;
    endcase
  end

  assign busy_o = busy_q;
  assign iter_o = iter_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      nb_q   <= '0;
      lim_q  <= '0;
      iter_q <= '0;
    end else if (clear_i) begin
      nb_q   <= '0;
      lim_q  <= '0;
      iter_q <= '0;
    end else if (state_q == IDLE && start_i) begin
      nb_q   <= cfg_nb_iter_i;
      lim_q  <= cfg_cnt_limit_i;
      iter_q <= '0;
    end else if (state_q == UPDATE && !last_iter) begin
      iter_q <= iter_q + ITER_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sdone_q <= '0;
      edone_q <= 1'b0;
      for (int j = 0; j < N_OUT; j++) cnt_q[j] <= '0;
    end else if (clear_i || accept) begin
      sdone_q <= '0;
      edone_q <= 1'b0;
      for (int j = 0; j < N_OUT; j++) cnt_q[j] <= '0;
    end else if (state_q == COMPUTE) begin
      sdone_q <= sdone_q | stream_done_i;
      edone_q <= edone_q | engine_done_i;
      // saturate: beats past the limit are dropped
      for (int j = 0; j < N_OUT; j++)
        if (out_beat_i[j] && cnt_q[j] != lim_q)
          cnt_q[j] <= cnt_q[j] + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multi_dataflow_job_fsm.sv
// Directed scoreboard bench for multi_dataflow_job_fsm
// (N_IN=2, N_OUT=1).
module tb_multi_dataflow_job_fsm;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        clear_i = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] cfg_nb_iter_i = '0;
  logic [31:0] cfg_cnt_limit_i = '0;
  logic [2:0]  stream_req_o;
  logic [2:0]  stream_ready_i = '0;
  logic [2:0]  stream_done_i = '0;
  logic [0:0]  out_beat_i = '0;
  logic        engine_start_o;
  logic        engine_done_i = 1'b0;
  logic        busy_o;
  logic [31:0] iter_o;
  logic        done_o;

  int n_cmp = 0;
  int n_err = 0;
  int n_start = 0;
  int n_done = 0;
  int unsigned exp_start_q[$];
  int unsigned exp_done_q[$];

  always #5 clk = ~clk;

  multi_dataflow_job_fsm #(
    .N_IN(2), .N_OUT(1), .CNT_W(32), .ITER_W(32)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .clear_i(clear_i),
    .start_i(start_i),
    .cfg_nb_iter_i(cfg_nb_iter_i),
    .cfg_cnt_limit_i(cfg_cnt_limit_i),
    .stream_req_o(stream_req_o),
    .stream_ready_i(stream_ready_i),
    .stream_done_i(stream_done_i),
    .out_beat_i(out_beat_i),
    .engine_start_o(engine_start_o),
    .engine_done_i(engine_done_i),
    .busy_o(busy_o),
    .iter_o(iter_o),
    .done_o(done_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // sample pulses against the scoreboard, then advance one cycle
  task automatic cyc;
    #1;
    if (engine_start_o === 1'b1) begin
      n_start++;
      if (exp_start_q.size() == 0)
        chk("unexpected_start", 64'(engine_start_o), 64'd0);
      else
        chk("start_iter", 64'(iter_o), 64'(exp_start_q.pop_front()));
    end
    if (done_o === 1'b1) begin
      n_done++;
      if (exp_done_q.size() == 0)
        chk("unexpected_done", 64'(done_o), 64'd0);
      else
        chk("done_iter", 64'(iter_o), 64'(exp_done_q.pop_front()));
    end
    @(posedge clk);
    #2;
  endtask

  task automatic start_job(input int nb, input int lim);
    cfg_nb_iter_i   = 32'(nb);
    cfg_cnt_limit_i = 32'(lim);
    start_i = 1'b1;
    #1;
    chk("busy_idle", 64'(busy_o), 64'd0);
    cyc;
    start_i = 1'b0;
    // changes after sampling must not affect the running job
    cfg_nb_iter_i   = 32'd7;
    cfg_cnt_limit_i = 32'd9;
  endtask

  task automatic req_phase(input int partial);
    for (int i = 0; i < partial; i++) begin
      stream_ready_i = 3'b011;
      #1;
      chk("req_partial", 64'(stream_req_o), 64'h7);
      chk("start_partial", 64'(engine_start_o), 64'd0);
      cyc;
    end
    stream_ready_i = 3'b111;
    #1;
    chk("req_accept", 64'(stream_req_o), 64'h7);
    chk("busy_req", 64'(busy_o), 64'd1);
    cyc;
    stream_ready_i = 3'b000;
  endtask

  // ends in the cycle after UPDATE (REQ or TERMINATE), without advancing
  task automatic compute_phase(input int lim, input int nbeats,
                               input bit dones_first, input bit last);
    int e;
    bit dn;
    e = dones_first ? lim : nbeats;
    for (int k = 0; k <= e + 3; k++) begin
      out_beat_i = dones_first ? 1'((k >= 1) && (k <= nbeats))
                               : 1'(k < nbeats);
      dn = dones_first ? (k == 0) : (k == nbeats);
      stream_done_i = {3{dn}};
      engine_done_i = dn;
      #1;
      if (k == e + 3) begin
        if (last) chk("done_at_exit", 64'(done_o), 64'd1);
        else chk("req_at_exit", 64'(stream_req_o), 64'h7);
        out_beat_i = '0;
        stream_done_i = '0;
        engine_done_i = 1'b0;
      end else begin
        chk("no_exit_yet", 64'({done_o, stream_req_o}), 64'd0);
        cyc;
      end
    end
  endtask

  initial begin
    #1;
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_req", 64'(stream_req_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_start", 64'(engine_start_o), 64'd0);
    chk("rst_iter", 64'(iter_o), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_ni = 1'b1;
    cyc;

    // single iteration, beats then dones
    exp_start_q.push_back(0);
    exp_done_q.push_back(0);
    start_job(0, 4);
    req_phase(0);
    compute_phase(4, 4, 1'b0, 1'b1);
    cyc;
    chk("j1_busy_low", 64'(busy_o), 64'd0);
    chk("j1_iter", 64'(iter_o), 64'd0);
    chk("j1_starts", 64'(n_start), 64'd1);

    // three iterations
    exp_start_q.push_back(0);
    exp_start_q.push_back(1);
    exp_start_q.push_back(2);
    exp_done_q.push_back(2);
    start_job(2, 3);
    for (int it = 0; it < 3; it++) begin
      req_phase(0);
      compute_phase(3, 3, it == 1, it == 2);
    end
    cyc;
    chk("j2_iter_hold", 64'(iter_o), 64'd2);
    chk("j2_starts", 64'(n_start), 64'd4);
    chk("j2_dones", 64'(n_done), 64'd2);

    // partial ready for 5 cycles
    exp_start_q.push_back(0);
    exp_done_q.push_back(0);
    start_job(0, 1);
    req_phase(5);
    compute_phase(1, 1, 1'b1, 1'b1);
    cyc;
    chk("j3_starts", 64'(n_start), 64'd5);

    // saturation: lim=2, 5 beats, dones first
    exp_start_q.push_back(0);
    exp_done_q.push_back(0);
    start_job(0, 2);
    req_phase(0);
    compute_phase(2, 5, 1'b1, 1'b1);
    cyc;

    // lim=0 completes on dones alone
    exp_start_q.push_back(0);
    exp_done_q.push_back(0);
    start_job(0, 0);
    req_phase(0);
    compute_phase(0, 0, 1'b0, 1'b1);
    cyc;

    // clear in COMPUTE of iteration 1
    exp_start_q.push_back(0);
    exp_start_q.push_back(1);
    start_job(3, 1);
    req_phase(0);
    compute_phase(1, 1, 1'b0, 1'b0);
    req_phase(0);
    clear_i = 1'b1;
    out_beat_i = 1'b1;
    stream_done_i = 3'b111;
    engine_done_i = 1'b1;
    cyc;
    clear_i = 1'b0;
    out_beat_i = 1'b0;
    stream_done_i = '0;
    engine_done_i = 1'b0;
    #1;
    chk("clr_busy", 64'(busy_o), 64'd0);
    chk("clr_req", 64'(stream_req_o), 64'd0);
    chk("clr_iter", 64'(iter_o), 64'd0);
    chk("clr_done", 64'(done_o), 64'd0);
    for (int i = 0; i < 3; i++) cyc;
    exp_start_q.push_back(0);
    exp_done_q.push_back(0);
    start_job(0, 1);
    req_phase(0);
    compute_phase(1, 1, 1'b0, 1'b1);
    cyc;
    chk("clr_rerun_iter", 64'(iter_o), 64'd0);

    // asynchronous reset mid-job
    exp_start_q.push_back(0);
    start_job(1, 1);
    req_phase(0);
    #1;
    rst_ni = 1'b0;
    #1;
    chk("arst_busy", 64'(busy_o), 64'd0);
    chk("arst_req", 64'(stream_req_o), 64'd0);
    chk("arst_iter", 64'(iter_o), 64'd0);
    chk("arst_done", 64'(done_o), 64'd0);
    @(posedge clk);
    #2;
    rst_ni = 1'b1;
    cyc;
    chk("arst_idle", 64'(busy_o), 64'd0);

    // start_i held through a whole job, incl. TERMINATE
    exp_start_q.push_back(0);
    exp_done_q.push_back(0);
    start_job(0, 2);
    start_i = 1'b1;
    req_phase(0);
    compute_phase(2, 2, 1'b0, 1'b1);
    cyc;
    start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ign_busy", 64'(busy_o), 64'd0);
      cyc;
    end

    chk("total_starts", 64'(n_start), 64'd12);
    chk("total_dones", 64'(n_done), 64'd7);
    chk("start_q_empty", 64'(exp_start_q.size()), 64'd0);
    chk("done_q_empty", 64'(exp_done_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
